// File: rtl/fadd_arbiter.sv
// rtl/fadd_arbiter.sv - two-requester round-robin front end for a shared pipelined fadd
// Issues one operation per cycle, tags it through a LAT-deep shift register and reports results in order.
module fadd_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x1,
  input  logic [31:0] req0_x2,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x1,
  input  logic [31:0] req1_x2,
  input  logic        req1_sub,
  output logic [31:0] fadd_x1,
  output logic [31:0] fadd_x2,
  input  logic [31:0] fadd_y,
  input  logic        fadd_ovf,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_y,
  output logic        rsp_ovf,
  output logic        busy
);

  logic           lg;
  logic [LAT-1:0] tag_valid;
  logic [LAT-1:0] tag_id;
  logic           issue;
  logic           grant_id;

  // lg=1 means requester 1 won last, so requester 0 takes the next contended slot.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        req0_ready = lg;
        req1_ready = !lg;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign issue    = req0_ready | req1_ready;
  assign grant_id = req1_ready;

  always_comb begin
    fadd_x1 = 32'h0;
    fadd_x2 = 32'h0;
    if (req0_ready) begin
      fadd_x1 = req0_x1;
      fadd_x2 = {req0_x2[31] ^ req0_sub, req0_x2[30:0]};
    end else if (req1_ready) begin
      fadd_x1 = req1_x1;
      fadd_x2 = {req1_x2[31] ^ req1_sub, req1_x2[30:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lg        <= 1'b1;
      tag_valid <= '0;
      tag_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_y     <= 32'h0;
      rsp_ovf   <= 1'b0;
    end else begin
      if (issue) lg <= grant_id;
      tag_valid[0] <= issue;
      tag_id[0]    <= grant_id;
      for (int i = 1; i < LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
      // The last tag stage lines up with the fadd output for that operation.
      rsp_valid <= tag_valid[LAT-1];
      if (tag_valid[LAT-1]) begin
        rsp_id  <= tag_id[LAT-1];
        rsp_y   <= fadd_y;
        rsp_ovf <= fadd_ovf;
      end
    end
  end

  assign busy = (|tag_valid) | rsp_valid;

endmodule

// File: tb/tb_fadd_arbiter.sv
// tb/tb_fadd_arbiter.sv - table-driven bench for fadd_arbiter with a lookup-table fadd stub
module tb_fadd_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_sub;
  logic [31:0] req0_x1, req0_x2;
  logic        req1_valid, req1_ready, req1_sub;
  logic [31:0] req1_x1, req1_x2;
  logic [31:0] fadd_x1, fadd_x2, fadd_y;
  logic        fadd_ovf;
  logic        rsp_valid, rsp_id, rsp_ovf, busy;
  logic [31:0] rsp_y;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fadd_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x1(req0_x1), .req0_x2(req0_x2), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x1(req1_x1), .req1_x2(req1_x2), .req1_sub(req1_sub),
    .fadd_x1(fadd_x1), .fadd_x2(fadd_x2), .fadd_y(fadd_y), .fadd_ovf(fadd_ovf),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  // Stand-in fadd: known IEEE cases from a table, otherwise an integer sum with ovf = x1[0].
  function automatic logic [32:0] fmodel(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return {1'b0, 32'h40400000};
    if (a == 32'h3F800000 && b == 32'hBF800000) return {1'b0, 32'h00000000};
    if (a == 32'h40A00000 && b == 32'hC0400000) return {1'b0, 32'h40000000};
    if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) return {1'b1, 32'h7F800000};
    return {a[0], a + b};
  endfunction

  logic [32:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= fmodel(fadd_x1, fadd_x2);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign fadd_y   = pipe[LAT-1][31:0];
  assign fadd_ovf = pipe[LAT-1][32];

  typedef struct {
    logic        v0, v1;
    logic [31:0] a0, b0;
    logic        s0;
    logic [31:0] a1, b1;
    logic        s1;
    logic        r0, r1;
    logic [31:0] fx1, fx2;
    logic        rv, rid;
    logic [31:0] ry;
    logic        ro, bz;
  } vec_t;

  vec_t vec [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic s0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic s1);
    req0_valid = v0; req0_x1 = a0; req0_x2 = b0; req0_sub = s0;
    req1_valid = v1; req1_x1 = a1; req1_x2 = b1; req1_sub = s1;
  endtask

  initial begin
    vec[0]  = '{1,1,32'h3F800000,32'h40000000,0,32'h3F800000,32'h3F800000,1, 1,0,32'h3F800000,32'h40000000, 0,0,32'h0,0,0};
    vec[1]  = '{0,1,32'h0,32'h0,0,32'h3F800000,32'h3F800000,1, 0,1,32'h3F800000,32'hBF800000, 0,0,32'h0,0,1};
    vec[2]  = '{0,0,32'h0,32'h0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0, 0,0,32'h0,0,1};
    vec[3]  = '{0,0,32'h0,32'h0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0, 1,0,32'h40400000,0,1};
    vec[4]  = '{0,1,32'h0,32'h0,0,32'h40A00000,32'h40400000,1, 0,1,32'h40A00000,32'hC0400000, 1,1,32'h0,0,1};
    vec[5]  = '{0,0,32'h0,32'h0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0, 0,1,32'h0,0,1};
    vec[6]  = '{0,0,32'h0,32'h0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0, 0,1,32'h0,0,1};
    vec[7]  = '{0,0,32'h0,32'h0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0, 1,1,32'h40000000,0,1};
    vec[8]  = '{1,0,32'h1,32'h2,0,32'h0,32'h0,0, 1,0,32'h1,32'h2, 0,1,32'h40000000,0,0};
    vec[9]  = '{0,0,32'h0,32'h0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0, 0,1,32'h40000000,0,1};
    vec[10] = '{0,0,32'h0,32'h0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0, 0,1,32'h40000000,0,1};
    vec[11] = '{0,0,32'h0,32'h0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0, 1,0,32'h3,1,1};
    vec[12] = '{1,0,32'h10,32'h20,0,32'h0,32'h0,0, 1,0,32'h10,32'h20, 0,0,32'h3,1,0};
    vec[13] = '{0,0,32'h0,32'h0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0, 0,0,32'h3,1,1};
    vec[14] = '{0,0,32'h0,32'h0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0, 0,0,32'h3,1,1};
    vec[15] = '{0,0,32'h0,32'h0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0, 1,0,32'h30,0,1};
    vec[16] = '{0,0,32'h0,32'h0,0,32'h0,32'h0,0, 0,0,32'h0,32'h0, 0,0,32'h30,0,0};

    rst = 1'b1;
    drive(1, 32'h0, 32'h0, 0, 1, 32'h0, 32'h0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_ready0", {31'b0, req0_ready}, 32'd0);
    chk("reset_ready1", {31'b0, req1_ready}, 32'd0);

    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      rst = 1'b0;
      drive(vec[c].v0, vec[c].a0, vec[c].b0, vec[c].s0, vec[c].v1, vec[c].a1, vec[c].b1, vec[c].s1);
      #1;
      chk($sformatf("c%0d_ready0", c), {31'b0, req0_ready}, {31'b0, vec[c].r0});
      chk($sformatf("c%0d_ready1", c), {31'b0, req1_ready}, {31'b0, vec[c].r1});
      chk($sformatf("c%0d_fadd_x1", c), fadd_x1, vec[c].fx1);
      chk($sformatf("c%0d_fadd_x2", c), fadd_x2, vec[c].fx2);
      chk($sformatf("c%0d_rsp_valid", c), {31'b0, rsp_valid}, {31'b0, vec[c].rv});
      chk($sformatf("c%0d_rsp_id", c), {31'b0, rsp_id}, {31'b0, vec[c].rid});
      chk($sformatf("c%0d_rsp_y", c), rsp_y, vec[c].ry);
      chk($sformatf("c%0d_rsp_ovf", c), {31'b0, rsp_ovf}, {31'b0, vec[c].ro});
      chk($sformatf("c%0d_busy", c), {31'b0, busy}, {31'b0, vec[c].bz});
    end

    // Both held valid for 8 cycles; last grant was requester 0, so requester 1 goes first.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k < 8) drive(1, 32'h100, 32'h0, 0, 1, 32'h200, 32'h0, 0);
      else       drive(0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
      #1;
      if (k < 8) begin
        chk($sformatf("alt%0d_ready1", k), {31'b0, req1_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("alt%0d_ready0", k), {31'b0, req0_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
      end
      if (k >= 3 && k < 11) begin
        chk($sformatf("alt%0d_rsp_valid", k), {31'b0, rsp_valid}, 32'd1);
        chk($sformatf("alt%0d_rsp_id", k), {31'b0, rsp_id}, ((k - 3) % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("alt%0d_rsp_y", k), rsp_y, ((k - 3) % 2 == 0) ? 32'h200 : 32'h100);
      end else begin
        chk($sformatf("alt%0d_rsp_valid", k), {31'b0, rsp_valid}, 32'd0);
      end
    end

    // Overflowing sum: flag and value come straight from the fadd.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) drive(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 0, 32'h0, 32'h0, 0);
      else        drive(0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
      #1;
      if (k == 3) begin
        chk("ovf_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("ovf_rsp_y", rsp_y, 32'h7F800000);
        chk("ovf_rsp_ovf", {31'b0, rsp_ovf}, 32'd1);
        chk("ovf_rsp_id", {31'b0, rsp_id}, 32'd0);
      end
    end

    // Reset right after an issue drops the operation and restores requester-0 priority.
    @(negedge clk);
    drive(1, 32'h5, 32'h6, 0, 0, 32'h0, 32'h0, 0);
    #1;
    chk("mid_issue_ready0", {31'b0, req0_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_busy", {31'b0, busy}, 32'd0);
    chk("post_reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk($sformatf("post_reset_quiet%0d", k), {31'b0, rsp_valid}, 32'd0);
    end
    @(negedge clk);
    drive(1, 32'h1, 32'h1, 0, 1, 32'h2, 32'h2, 0);
    #1;
    chk("post_reset_ready0", {31'b0, req0_ready}, 32'd1);
    chk("post_reset_ready1", {31'b0, req1_ready}, 32'd0);
    @(negedge clk);
    drive(0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
